// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: converts the write-back cache's line read/write interface into AXI4 bursts.
// Independent read and write FSMs; a read to a line whose write-back is pending waits for B.
module cache_axi_bridge #(
   parameter int unsigned LINE_WORDS = 4,
   parameter bit          RAW_CHECK  = 1'b1
) (
   input  logic                       clk,
   input  logic                       resetn,
   // cache read side
   input  logic                       rd_req_i,
   input  logic [2:0]                 rd_type_i,
   input  logic [31:0]                rd_addr_i,
   output logic                       rd_rdy_o,
   output logic                       ret_valid_o,
   output logic                       ret_last_o,
   output logic [31:0]                ret_data_o,
   // cache write side
   input  logic                       wr_req_i,
   input  logic [2:0]                 wr_type_i,
   input  logic [31:0]                wr_addr_i,
   input  logic [3:0]                 wr_wstrb_i,
   input  logic [32*LINE_WORDS-1:0]   wr_data_i,
   output logic                       wr_rdy_o,
   // AXI AR / R
   output logic [31:0]                araddr_o,
   output logic [7:0]                 arlen_o,
   output logic [2:0]                 arsize_o,
   output logic [1:0]                 arburst_o,
   output logic                       arvalid_o,
   input  logic                       arready_i,
   input  logic [31:0]                rdata_i,
   input  logic [1:0]                 rresp_i,
   input  logic                       rlast_i,
   input  logic                       rvalid_i,
   output logic                       rready_o,
   // AXI AW / W / B
   output logic [31:0]                awaddr_o,
   output logic [7:0]                 awlen_o,
   output logic [2:0]                 awsize_o,
   output logic [1:0]                 awburst_o,
   output logic                       awvalid_o,
   input  logic                       awready_i,
   output logic [31:0]                wdata_o,
   output logic [3:0]                 wstrb_o,
   output logic                       wlast_o,
   output logic                       wvalid_o,
   input  logic                       wready_i,
   input  logic [1:0]                 bresp_i,
   input  logic                       bvalid_i,
   output logic                       bready_o
);

   localparam logic [2:0]  TYPE_LINE = 3'd4;
   localparam logic [7:0]  LINE_LEN  = 8'(LINE_WORDS - 1);
   localparam int unsigned IDX_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

   rd_state_e                   rd_state_q, rd_state_d;
   logic [31:0]                 araddr_q, araddr_d;
   logic [7:0]                  arlen_q, arlen_d;
   logic [2:0]                  arsize_q, arsize_d;
   wr_state_e                   wr_state_q, wr_state_d;
   logic [31:0]                 awaddr_q, awaddr_d;
   logic [7:0]                  awlen_q, awlen_d;
   logic [2:0]                  awsize_q, awsize_d;
   logic [3:0]                  wstrb_q, wstrb_d;
   logic [IDX_W-1:0]            cnt_q, cnt_d;
   logic [LINE_WORDS-1:0][31:0] wbuf_q;
   logic                        wr_accept, line_hit, beat_last, unused_ok;

   assign wr_rdy_o  = (wr_state_q == W_IDLE);
   assign wr_accept = wr_req_i && wr_rdy_o;

   // A read may not overtake a write-back to the same line, including one accepted this cycle.
   assign line_hit  = ((wr_state_q != W_IDLE) && (rd_addr_i[31:4] == awaddr_q[31:4]))
                   || (wr_accept && (rd_addr_i[31:4] == wr_addr_i[31:4]));
   assign rd_rdy_o  = (rd_state_q == R_IDLE) && !(RAW_CHECK && line_hit);
   assign beat_last = (8'(cnt_q) == awlen_q);

   // NOTE: every variable is given its hold value first so no path through the case infers a latch.
   always_comb begin
      rd_state_d = rd_state_q;
      araddr_d   = araddr_q;
      arlen_d    = arlen_q;
      arsize_d   = arsize_q;
      unique case (rd_state_q)
         R_IDLE: if (rd_req_i && rd_rdy_o) begin
            rd_state_d = R_ADDR;
            if (rd_type_i == TYPE_LINE) begin
               araddr_d = {rd_addr_i[31:4], 4'h0};
               arlen_d  = LINE_LEN;
               arsize_d = 3'd2;
            end else begin
               araddr_d = rd_addr_i;
               arlen_d  = 8'd0;
               arsize_d = rd_type_i;
            end
         end
         R_ADDR:  if (arready_i) rd_state_d = R_DATA;
         R_DATA:  if (rvalid_i && rlast_i) rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      wr_state_d = wr_state_q;
      awaddr_d   = awaddr_q;
      awlen_d    = awlen_q;
      awsize_d   = awsize_q;
      wstrb_d    = wstrb_q;
      cnt_d      = cnt_q;
      unique case (wr_state_q)
         W_IDLE: if (wr_accept) begin
            wr_state_d = W_ADDR;
            if (wr_type_i == TYPE_LINE) begin
               awaddr_d = {wr_addr_i[31:4], 4'h0};
               awlen_d  = LINE_LEN;
               awsize_d = 3'd2;
               wstrb_d  = 4'hf;
            end else begin
               awaddr_d = wr_addr_i;
               awlen_d  = 8'd0;
               awsize_d = wr_type_i;
               wstrb_d  = wr_wstrb_i;
            end
         end
         W_ADDR: if (awready_i) wr_state_d = W_DATA;
         W_DATA: if (wready_i) begin
            if (beat_last) begin
               cnt_d      = '0;
               wr_state_d = W_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         W_RESP:  if (bvalid_i) wr_state_d = W_IDLE;
         default: wr_state_d = W_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments make every register sample pre-edge values, whatever the order.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_state_q <= R_IDLE;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arsize_q   <= '0;
         wr_state_q <= W_IDLE;
         awaddr_q   <= '0;
         awlen_q    <= '0;
         awsize_q   <= '0;
         wstrb_q    <= '0;
         cnt_q      <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         araddr_q   <= araddr_d;
         arlen_q    <= arlen_d;
         arsize_q   <= arsize_d;
         wr_state_q <= wr_state_d;
         awaddr_q   <= awaddr_d;
         awlen_q    <= awlen_d;
         awsize_q   <= awsize_d;
         wstrb_q    <= wstrb_d;
         cnt_q      <= cnt_d;
      end
   end

   // NOTE: the line buffer is deliberately not reset; it is only read after an accepted write fills it.
   always_ff @(posedge clk) begin
      if (wr_accept) wbuf_q <= wr_data_i;
   end

   assign araddr_o    = araddr_q;
   assign arlen_o     = arlen_q;
   assign arsize_o    = arsize_q;
   assign arburst_o   = 2'b01;
   assign arvalid_o   = (rd_state_q == R_ADDR);
   assign rready_o    = (rd_state_q == R_DATA);
   assign ret_valid_o = (rd_state_q == R_DATA) && rvalid_i;
   assign ret_last_o  = (rd_state_q == R_DATA) && rlast_i;
   assign ret_data_o  = rdata_i;

   assign awaddr_o    = awaddr_q;
   assign awlen_o     = awlen_q;
   assign awsize_o    = awsize_q;
   assign awburst_o   = 2'b01;
   assign awvalid_o   = (wr_state_q == W_ADDR);
   assign wvalid_o    = (wr_state_q == W_DATA);
   assign wdata_o     = wbuf_q[cnt_q];
   assign wstrb_o     = wstrb_q;
   assign wlast_o     = (wr_state_q == W_DATA) && beat_last;
   assign bready_o    = (wr_state_q == W_RESP);

   // Response codes carry no information the cache can act on.
   assign unused_ok   = ^{rresp_i, bresp_i};

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge: scoreboarded AR/R and AW/W/B transactions,
// RAW blocking, concurrent read/write, AR back-pressure and reset mid-burst.
module tb_cache_axi_bridge;

   localparam int LW = 4;

   logic            clk = 1'b0;
   logic            resetn;
   logic            rd_req_i, rd_rdy_o, ret_valid_o, ret_last_o;
   logic [2:0]      rd_type_i;
   logic [31:0]     rd_addr_i, ret_data_o;
   logic            wr_req_i, wr_rdy_o;
   logic [2:0]      wr_type_i;
   logic [31:0]     wr_addr_i;
   logic [3:0]      wr_wstrb_i;
   logic [32*LW-1:0] wr_data_i;
   logic [31:0]     araddr_o, awaddr_o, rdata_i, wdata_o;
   logic [7:0]      arlen_o, awlen_o;
   logic [2:0]      arsize_o, awsize_o;
   logic [1:0]      arburst_o, awburst_o, rresp_i, bresp_i;
   logic            arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;
   logic            awvalid_o, awready_i, wlast_o, wvalid_o, wready_i, bvalid_i, bready_o;
   logic [3:0]      wstrb_o;

   typedef struct { logic [31:0] data; logic last; } rbeat_t;
   typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } wbeat_t;

   rbeat_t      rq[$];
   wbeat_t      wq[$];
   logic [31:0] exp_araddr, exp_awaddr;
   logic [7:0]  exp_arlen, exp_awlen;
   logic [2:0]  exp_arsize, exp_awsize;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   cache_axi_bridge #(.LINE_WORDS(LW), .RAW_CHECK(1'b1)) dut (
      .clk(clk), .resetn(resetn),
      .rd_req_i(rd_req_i), .rd_type_i(rd_type_i), .rd_addr_i(rd_addr_i), .rd_rdy_o(rd_rdy_o),
      .ret_valid_o(ret_valid_o), .ret_last_o(ret_last_o), .ret_data_o(ret_data_o),
      .wr_req_i(wr_req_i), .wr_type_i(wr_type_i), .wr_addr_i(wr_addr_i), .wr_wstrb_i(wr_wstrb_i),
      .wr_data_i(wr_data_i), .wr_rdy_o(wr_rdy_o),
      .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
      .arvalid_o(arvalid_o), .arready_i(arready_i),
      .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
      .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
      .awvalid_o(awvalid_o), .awready_i(awready_i),
      .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
      .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
   );

   // Reference model for a read request: expected AR payload plus the beats the slave will return.
   task automatic prep_read(input logic [31:0] addr, input logic [2:0] typ);
      int nb;
      if (typ == 3'd4) begin
         exp_araddr = {addr[31:4], 4'h0}; exp_arlen = 8'(LW - 1); exp_arsize = 3'd2;
      end else begin
         exp_araddr = addr; exp_arlen = 8'd0; exp_arsize = typ;
      end
      nb = int'(exp_arlen) + 1;
      for (int i = 0; i < nb; i++) rq.push_back('{data: $urandom, last: (i == nb - 1)});
      rd_type_i = typ;
      rd_addr_i = addr;
   endtask

   // Reference model for a write request: expected AW payload plus expected W beats.
   task automatic prep_write(input logic [31:0] addr, input logic [2:0] typ, input logic [3:0] strb,
                             input logic [127:0] data);
      int nb;
      if (typ == 3'd4) begin
         exp_awaddr = {addr[31:4], 4'h0}; exp_awlen = 8'(LW - 1); exp_awsize = 3'd2;
      end else begin
         exp_awaddr = addr; exp_awlen = 8'd0; exp_awsize = typ;
      end
      nb = int'(exp_awlen) + 1;
      for (int i = 0; i < nb; i++)
         wq.push_back('{data: data[32*i +: 32], strb: (typ == 3'd4) ? 4'hf : strb, last: (i == nb - 1)});
      wr_type_i  = typ;
      wr_addr_i  = addr;
      wr_wstrb_i = strb;
      wr_data_i  = data;
   endtask

   // Runs AR (after ar_wait stalled cycles) and the R beats of a read accepted at the previous edge.
   task automatic finish_read(input int ar_wait);
      rbeat_t e;
      int     c;
      @(negedge clk);
      rd_req_i = 1'b0;
      for (int i = 0; i <= ar_wait; i++) begin
         arready_i = (i == ar_wait);
         #1;
         n_cmp++; if (arvalid_o !== 1'b1) begin n_err++; $display("FAIL arvalid: got %b want 1", arvalid_o); end
         n_cmp++; if (araddr_o !== exp_araddr) begin n_err++; $display("FAIL araddr: got %h want %h", araddr_o, exp_araddr); end
         n_cmp++; if (arlen_o !== exp_arlen) begin n_err++; $display("FAIL arlen: got %0d want %0d", arlen_o, exp_arlen); end
         n_cmp++; if (arsize_o !== exp_arsize) begin n_err++; $display("FAIL arsize: got %0d want %0d", arsize_o, exp_arsize); end
         n_cmp++; if (arburst_o !== 2'b01) begin n_err++; $display("FAIL arburst: got %b want 01", arburst_o); end
         n_cmp++; if (rd_rdy_o !== 1'b0) begin n_err++; $display("FAIL rd_rdy_busy: got %b want 0", rd_rdy_o); end
         @(negedge clk);
      end
      arready_i = 1'b0;
      c = 0;
      while (rq.size() > 0 && c < 20) begin
         if (c == 1) begin
            rvalid_i = 1'b0; rlast_i = 1'b0;
            #1;
            n_cmp++; if (ret_valid_o !== 1'b0) begin n_err++; $display("FAIL ret_valid_gap: got %b want 0", ret_valid_o); end
            n_cmp++; if (rready_o !== 1'b1) begin n_err++; $display("FAIL rready_gap: got %b want 1", rready_o); end
         end else begin
            e = rq.pop_front();
            rvalid_i = 1'b1; rdata_i = e.data; rlast_i = e.last;
            #1;
            n_cmp++; if (ret_valid_o !== 1'b1) begin n_err++; $display("FAIL ret_valid: got %b want 1", ret_valid_o); end
            n_cmp++; if (ret_data_o !== e.data) begin n_err++; $display("FAIL ret_data: got %h want %h", ret_data_o, e.data); end
            n_cmp++; if (ret_last_o !== e.last) begin n_err++; $display("FAIL ret_last: got %b want %b", ret_last_o, e.last); end
            n_cmp++; if (rready_o !== 1'b1) begin n_err++; $display("FAIL rready: got %b want 1", rready_o); end
         end
         c++;
         @(negedge clk);
      end
      rvalid_i = 1'b0; rlast_i = 1'b0;
      #1;
      n_cmp++; if (rready_o !== 1'b0) begin n_err++; $display("FAIL rready_idle: got %b want 0", rready_o); end
      n_cmp++; if (rd_rdy_o !== 1'b1) begin n_err++; $display("FAIL rd_rdy_idle: got %b want 1", rd_rdy_o); end
   endtask

   // Runs AW, W (wready pattern 1,0,1,...) and B of a write accepted at the previous edge.
   // With blk set, a pending read to the same line must see rd_rdy=0 throughout.
   task automatic finish_write(input int aw_wait, input bit blk);
      wbeat_t e;
      int     c;
      @(negedge clk);
      wr_req_i = 1'b0;
      for (int i = 0; i <= aw_wait; i++) begin
         awready_i = (i == aw_wait);
         #1;
         n_cmp++; if (awvalid_o !== 1'b1) begin n_err++; $display("FAIL awvalid: got %b want 1", awvalid_o); end
         n_cmp++; if (awaddr_o !== exp_awaddr) begin n_err++; $display("FAIL awaddr: got %h want %h", awaddr_o, exp_awaddr); end
         n_cmp++; if (awlen_o !== exp_awlen) begin n_err++; $display("FAIL awlen: got %0d want %0d", awlen_o, exp_awlen); end
         n_cmp++; if (awsize_o !== exp_awsize) begin n_err++; $display("FAIL awsize: got %0d want %0d", awsize_o, exp_awsize); end
         n_cmp++; if (awburst_o !== 2'b01) begin n_err++; $display("FAIL awburst: got %b want 01", awburst_o); end
         n_cmp++; if (wvalid_o !== 1'b0) begin n_err++; $display("FAIL wvalid_early: got %b want 0", wvalid_o); end
         if (blk) begin
            n_cmp++; if (rd_rdy_o !== 1'b0) begin n_err++; $display("FAIL raw_block_aw: got %b want 0", rd_rdy_o); end
         end
         @(negedge clk);
      end
      awready_i = 1'b0;
      c = 0;
      while (wq.size() > 0 && c < 20) begin
         wready_i = (c % 3 != 1);
         #1;
         n_cmp++; if (wr_rdy_o !== 1'b0) begin n_err++; $display("FAIL wr_rdy_busy: got %b want 0", wr_rdy_o); end
         if (blk) begin
            n_cmp++; if (rd_rdy_o !== 1'b0) begin n_err++; $display("FAIL raw_block_w: got %b want 0", rd_rdy_o); end
         end
         if (wvalid_o && wready_i) begin
            e = wq.pop_front();
            n_cmp++; if (wdata_o !== e.data) begin n_err++; $display("FAIL wdata: got %h want %h", wdata_o, e.data); end
            n_cmp++; if (wstrb_o !== e.strb) begin n_err++; $display("FAIL wstrb: got %h want %h", wstrb_o, e.strb); end
            n_cmp++; if (wlast_o !== e.last) begin n_err++; $display("FAIL wlast: got %b want %b", wlast_o, e.last); end
         end
         c++;
         @(negedge clk);
      end
      n_cmp++;
      if (wq.size() != 0) begin
         n_err++; $display("FAIL w_timeout: %0d beats outstanding want 0", wq.size());
         wq.delete();
      end
      wready_i = 1'b0;
      #1;
      n_cmp++; if (bready_o !== 1'b1) begin n_err++; $display("FAIL bready: got %b want 1", bready_o); end
      n_cmp++; if (wvalid_o !== 1'b0) begin n_err++; $display("FAIL wvalid_resp: got %b want 0", wvalid_o); end
      n_cmp++; if (wr_rdy_o !== 1'b0) begin n_err++; $display("FAIL wr_rdy_resp: got %b want 0", wr_rdy_o); end
      @(negedge clk);
      bvalid_i = 1'b1;
      bresp_i  = 2'b10;
      #1;
      n_cmp++; if (wr_rdy_o !== 1'b0) begin n_err++; $display("FAIL wr_rdy_bvalid: got %b want 0", wr_rdy_o); end
      if (blk) begin
         n_cmp++; if (rd_rdy_o !== 1'b0) begin n_err++; $display("FAIL raw_block_b: got %b want 0", rd_rdy_o); end
      end
      @(negedge clk);
      bvalid_i = 1'b0;
      bresp_i  = 2'b00;
      #1;
      n_cmp++; if (wr_rdy_o !== 1'b1) begin n_err++; $display("FAIL wr_rdy_after_b: got %b want 1", wr_rdy_o); end
      n_cmp++; if (bready_o !== 1'b0) begin n_err++; $display("FAIL bready_idle: got %b want 0", bready_o); end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      n_cmp++; if (arvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_arvalid: got %b want 0", arvalid_o); end
      n_cmp++; if (rready_o !== 1'b0) begin n_err++; $display("FAIL rst_rready: got %b want 0", rready_o); end
      n_cmp++; if (awvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_awvalid: got %b want 0", awvalid_o); end
      n_cmp++; if (wvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_wvalid: got %b want 0", wvalid_o); end
      n_cmp++; if (wlast_o !== 1'b0) begin n_err++; $display("FAIL rst_wlast: got %b want 0", wlast_o); end
      n_cmp++; if (bready_o !== 1'b0) begin n_err++; $display("FAIL rst_bready: got %b want 0", bready_o); end
      n_cmp++; if (ret_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_ret_valid: got %b want 0", ret_valid_o); end
      n_cmp++; if (rd_rdy_o !== 1'b1) begin n_err++; $display("FAIL rst_rd_rdy: got %b want 1", rd_rdy_o); end
      n_cmp++; if (wr_rdy_o !== 1'b1) begin n_err++; $display("FAIL rst_wr_rdy: got %b want 1", wr_rdy_o); end
   endtask

   task automatic test_read_line();
      prep_read(32'h1C00_0040, 3'd4);
      @(negedge clk);
      rd_req_i = 1'b1;
      #1;
      n_cmp++; if (rd_rdy_o !== 1'b1) begin n_err++; $display("FAIL rd_line_accept: got %b want 1", rd_rdy_o); end
      finish_read(0);
   endtask

   task automatic test_read_word();
      prep_read(32'h1C00_0044, 3'd2);
      @(negedge clk);
      rd_req_i = 1'b1;
      #1;
      n_cmp++; if (rd_rdy_o !== 1'b1) begin n_err++; $display("FAIL rd_word_accept: got %b want 1", rd_rdy_o); end
      finish_read(0);
      prep_read(32'h1C00_0047, 3'd0);
      @(negedge clk);
      rd_req_i = 1'b1;
      finish_read(1);
   endtask

   task automatic test_write_line();
      prep_write(32'h1C00_008C, 3'd4, 4'h3, {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000});
      @(negedge clk);
      wr_req_i = 1'b1;
      #1;
      n_cmp++; if (wr_rdy_o !== 1'b1) begin n_err++; $display("FAIL wr_line_accept: got %b want 1", wr_rdy_o); end
      finish_write(1, 1'b0);
   endtask

   task automatic test_write_word();
      prep_write(32'h1C00_0104, 3'd2, 4'h6, {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'h5EED_F00D});
      @(negedge clk);
      wr_req_i = 1'b1;
      finish_write(0, 1'b0);
   endtask

   task automatic test_raw_stall();
      prep_write(32'h1C00_0080, 3'd4, 4'h0, {32'h0BAD_0003, 32'h0BAD_0002, 32'h0BAD_0001, 32'h0BAD_0000});
      prep_read(32'h1C00_0088, 3'd2);
      @(negedge clk);
      wr_req_i = 1'b1;
      rd_req_i = 1'b1;
      #1;
      n_cmp++; if (wr_rdy_o !== 1'b1) begin n_err++; $display("FAIL raw_wr_accept: got %b want 1", wr_rdy_o); end
      n_cmp++; if (rd_rdy_o !== 1'b0) begin n_err++; $display("FAIL raw_same_cycle: got %b want 0", rd_rdy_o); end
      finish_write(0, 1'b1);
      n_cmp++; if (rd_rdy_o !== 1'b1) begin n_err++; $display("FAIL raw_release: got %b want 1", rd_rdy_o); end
      finish_read(0);
   endtask

   task automatic test_back_to_back();
      prep_write(32'h1C00_0080, 3'd4, 4'h0, {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000});
      prep_read(32'h1C00_00C0, 3'd4);
      @(negedge clk);
      wr_req_i = 1'b1;
      rd_req_i = 1'b1;
      #1;
      n_cmp++; if (wr_rdy_o !== 1'b1) begin n_err++; $display("FAIL b2b_wr_rdy: got %b want 1", wr_rdy_o); end
      n_cmp++; if (rd_rdy_o !== 1'b1) begin n_err++; $display("FAIL b2b_rd_rdy: got %b want 1", rd_rdy_o); end
      finish_read(0);
      finish_write(0, 1'b0);
   endtask

   task automatic test_ar_stall();
      prep_read(32'h1C00_0200, 3'd4);
      @(negedge clk);
      rd_req_i = 1'b1;
      finish_read(5);
   endtask

   task automatic test_reset_mid();
      wbeat_t e;
      prep_write(32'h1C00_0300, 3'd4, 4'h0, {32'hEEEE_0003, 32'hEEEE_0002, 32'hEEEE_0001, 32'hEEEE_0000});
      @(negedge clk);
      wr_req_i = 1'b1;
      @(negedge clk);
      wr_req_i  = 1'b0;
      awready_i = 1'b1;
      @(negedge clk);
      awready_i = 1'b0;
      wready_i  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) resetn = 1'b0;
         #1;
         e = wq.pop_front();
         n_cmp++; if (wvalid_o !== 1'b1) begin n_err++; $display("FAIL rstmid_wvalid: got %b want 1", wvalid_o); end
         n_cmp++; if (wdata_o !== e.data) begin n_err++; $display("FAIL rstmid_wdata: got %h want %h", wdata_o, e.data); end
         @(negedge clk);
      end
      resetn   = 1'b1;
      wready_i = 1'b0;
      wq.delete();
      #1;
      n_cmp++; if (wvalid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_wvalid_after: got %b want 0", wvalid_o); end
      n_cmp++; if (awvalid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_awvalid: got %b want 0", awvalid_o); end
      n_cmp++; if (wlast_o !== 1'b0) begin n_err++; $display("FAIL rstmid_wlast: got %b want 0", wlast_o); end
      n_cmp++; if (wr_rdy_o !== 1'b1) begin n_err++; $display("FAIL rstmid_wr_rdy: got %b want 1", wr_rdy_o); end
      n_cmp++; if (rd_rdy_o !== 1'b1) begin n_err++; $display("FAIL rstmid_rd_rdy: got %b want 1", rd_rdy_o); end
      // A fresh single-beat write must start from word 0 again.
      prep_write(32'h1C00_0400, 3'd2, 4'h9, {32'h0, 32'h0, 32'h0, 32'h1234_5678});
      @(negedge clk);
      wr_req_i = 1'b1;
      finish_write(0, 1'b0);
   endtask

   initial begin
      resetn = 1'b0;
      rd_req_i = 1'b0; rd_type_i = 3'd0; rd_addr_i = '0;
      wr_req_i = 1'b0; wr_type_i = 3'd0; wr_addr_i = '0; wr_wstrb_i = '0; wr_data_i = '0;
      arready_i = 1'b0; rdata_i = '0; rresp_i = 2'b00; rlast_i = 1'b0; rvalid_i = 1'b0;
      awready_i = 1'b0; wready_i = 1'b0; bresp_i = 2'b00; bvalid_i = 1'b0;
      test_reset();
      test_read_line();
      test_read_word();
      test_write_line();
      test_write_word();
      test_raw_stall();
      test_back_to_back();
      test_ar_stall();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
